elastic_pipe_reg: RTL and testbench
===================================

Name: elastic_pipe_reg

Overview:
Parametrised pipeline register with a val/rdy handshake on both sides, replacing bare enable-driven stage registers between processor pipeline stages. It holds up to two entries, using a skid slot to cut the combinational rdy path, and supports a synchronous squash for branch/jump flushes. Order is preserved. Latency is 1 cycle and throughput is 1 message/cycle.

Parameters:
p_nbits, 32, message width in bits
p_rst_val, 0, value loaded into both data registers on reset (p_nbits wide)
p_skid, 1, 1 = two-entry skid mode (registered in_rdy); 0 = single-entry mode (combinational in_rdy)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_val  input  1  upstream message valid
in_rdy  output  1  stage can accept a message
in_msg  input  p_nbits  upstream message
out_val  output  1  downstream message valid
out_rdy  input  1  downstream can accept
out_msg  output  p_nbits  message at head (entry M)
squash  input  1  drop all held entries at next edge
count  output  2  occupancy: 0, 1 or 2

Behaviour:
- Definitions: in_fire = in_val & in_rdy; out_fire = out_val & out_rdy.
- Storage: main entry M (head, drives out_msg) and skid entry S (p_skid=1 only).
- Reset (rst=0, asynchronous, independent of clk):
  - valid bits of M and S are cleared; both data registers are set to p_rst_val.
  - While rst=0: out_val=0, in_rdy=0, count=0, out_msg=p_rst_val.
  - First cycle after rst rises: in_rdy=1.
  - Reset mid-transfer discards everything held.
- State is pipe_state_t: EMPTY, ONE, FULL. FULL is reachable only when p_skid=1.
- p_skid=1 transitions:
  - in_rdy = (state != FULL) & !squash. It is a function of state and squash only, with no path from out_rdy.
  - EMPTY: in_fire -> ONE, M<=in_msg.
  - ONE, in_fire & out_fire -> ONE, M<=in_msg.
  - ONE, in_fire only -> FULL, S<=in_msg.
  - ONE, out_fire only -> EMPTY.
  - FULL: in_rdy=0. out_fire -> ONE, M<=S.
- p_skid=0 transitions:
  - in_rdy = ((state==EMPTY) | out_rdy) & !squash.
  - EMPTY, in_fire -> ONE.
  - ONE, in_fire & out_fire -> ONE with new M.
  - ONE, out_fire only -> EMPTY.
- out_val = (state != EMPTY). count = 0/1/2 for EMPTY/ONE/FULL.
- Data registers load only on the transitions listed above. out_msg stays stable while out_val & !out_rdy.
- squash=1 at an edge: next state is EMPTY regardless of other inputs.
  - in_rdy is forced 0, so nothing is accepted that cycle.
  - An out_fire in the same cycle still counts as delivered.
  - Data registers keep their old contents but are don't-care.
- The upstream side must hold in_msg stable while in_val & !in_rdy. The block does not check this.
- Simultaneous in_fire/out_fire never changes count except at the ONE->FULL and FULL->ONE edges described above.
- No arithmetic. All widths are exact p_nbits with no truncation.

Decomposition:
- Package elastic_pipe_pkg:
  - typedef enum logic [1:0] pipe_state_t {EMPTY=0, ONE=1, FULL=2}.
  - localparam for count width (2).
- One sub-module: elastic_reg_entry, a p_nbits data register with async active-low reset to p_rst_val and a load enable. It is instantiated twice (M, S); S is generated only when p_skid=1.
- State register and next-state/rdy logic live in elastic_pipe_reg.

Test Plan:
- Reset: hold rst=0 with random inputs, then release -> out_val=0, count=0, out_msg=p_rst_val during reset; in_rdy=1 on the first cycle after release. Assert rst=0 asynchronously mid-cycle in FULL -> out_val drops immediately and no message is emitted after release.
- Streaming (p_skid=1): out_rdy=1, send 0x11,0x22,0x33 on consecutive cycles -> out_msg shows 0x11,0x22,0x33 on cycles 1,2,3, count stays 1, no bubbles.
- Backpressure/skid: out_rdy=0, send 0xA0 then 0xA1 -> count=2 and in_rdy=0 while in_val holds 0xA2. Raise out_rdy -> outputs 0xA0,0xA1,0xA2 in order with nothing lost or duplicated.
- Squash in FULL with in_val=1, in_msg=0xFF -> next cycle count=0, out_val=0, 0xFF never appears at the output.
- Squash in the same cycle as out_fire of 0x55 -> 0x55 counts as delivered; next cycle EMPTY.
- p_skid=0, p_nbits=8: out_rdy=0 while ONE -> in_rdy=0. Raise out_rdy in the same cycle as in_val=1, in_msg=0x7E -> in_rdy=1 combinationally; 0x7E at the output next cycle with count=1.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared types and constants for the elastic pipeline register.
package elastic_pipe_pkg;

    localparam int unsigned COUNT_W = 2;

    // Occupancy of the stage; the encoding equals the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/elastic_reg_entry.sv
// One p_nbits-wide storage entry with load enable and async reset value.
module elastic_reg_entry #(
    parameter int                 p_nbits   = 32,
    parameter logic [p_nbits-1:0] p_rst_val = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    // Hold the entry; load only when the controller asks for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= p_rst_val;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline stage with val/rdy on both sides and synchronous squash.
// With p_skid=1 a second (skid) entry lets in_rdy depend only on local
// state, breaking the combinational ready chain between stages.
module elastic_pipe_reg
    import elastic_pipe_pkg::*;
#(
    parameter int                 p_nbits   = 32,
    parameter logic [p_nbits-1:0] p_rst_val = '0,
    parameter bit                 p_skid    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    input  logic               squash,
    output logic [COUNT_W-1:0] count
);

    pipe_state_t        state_q;
    pipe_state_t        state_d;
    logic               in_fire;
    logic               out_fire;
    logic               m_en;
    logic [p_nbits-1:0] m_d;
    logic [p_nbits-1:0] s_q;

    // Ready is gated by reset so nothing is accepted while held in reset.
    // In skid mode it never looks at out_rdy.
    assign in_rdy = rst & ~squash &
                    (p_skid ? (state_q != FULL) : ((state_q == EMPTY) | out_rdy));

    assign out_val  = (state_q != EMPTY);
    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;
    assign count    = state_q;

    // Head entry refills from skid when draining FULL, else from upstream.
    assign m_d = (state_q == FULL) ? s_q : in_msg;

    // Next-state and head-load decode; squash empties the stage and
    // leaves data untouched.
    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    m_en    = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    m_en = 1'b1;
                end else if (in_fire && p_skid) begin
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d = ONE;
                    m_en    = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (squash) begin
            state_d = EMPTY;
            m_en    = 1'b0;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    elastic_reg_entry #(
        .p_nbits   (p_nbits),
        .p_rst_val (p_rst_val)
    ) u_entry_m (
        .clk (clk),
        .rst (rst),
        .en  (m_en),
        .d   (m_d),
        .q   (out_msg)
    );

    generate
        if (p_skid) begin : g_skid
            logic s_en;

            // Skid entry captures the message arriving while the head stalls.
            assign s_en = (state_q == ONE) & in_fire & ~out_fire & ~squash;

            elastic_reg_entry #(
                .p_nbits   (p_nbits),
                .p_rst_val (p_rst_val)
            ) u_entry_s (
                .clk (clk),
                .rst (rst),
                .en  (s_en),
                .d   (in_msg),
                .q   (s_q)
            );
        end else begin : g_noskid
            assign s_q = p_rst_val;
        end
    endgenerate

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench for elastic_pipe_reg: skid (32-bit) and non-skid (8-bit)
// instances, with a scoreboard on the skid instance's output stream.
module tb_elastic_pipe_reg;

    localparam logic [31:0] RST1 = 32'hDEAD_BEEF;
    localparam logic [7:0]  RST0 = 8'h00;

    logic        clk;
    logic        rst;
    logic        in_val, in_rdy, out_val, out_rdy, squash;
    logic [31:0] in_msg, out_msg;
    logic [1:0]  count;

    logic        z_rst;
    logic        z_in_val, z_in_rdy, z_out_val, z_out_rdy, z_squash;
    logic [7:0]  z_in_msg, z_out_msg;
    logic [1:0]  z_count;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sb[$];

    elastic_pipe_reg #(.p_nbits(32), .p_rst_val(RST1), .p_skid(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg),
        .squash(squash), .count(count)
    );

    elastic_pipe_reg #(.p_nbits(8), .p_rst_val(RST0), .p_skid(1'b0)) dut0 (
        .clk(clk), .rst(z_rst), .in_val(z_in_val), .in_rdy(z_in_rdy), .in_msg(z_in_msg),
        .out_val(z_out_val), .out_rdy(z_out_rdy), .out_msg(z_out_msg),
        .squash(z_squash), .count(z_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push accepted messages, pop and compare delivered ones.
    always @(negedge clk) begin
        logic [31:0] exp;
        if (!rst) begin
            sb.delete();
        end else begin
            if (out_val && out_rdy) begin
                if (sb.size() == 0) begin
                    checks++;
                    assert (0) else begin
                        errors++;
                        $error("FAIL unexpected_out: observed %h expected no message", out_msg);
                    end
                end else begin
                    exp = sb.pop_front();
                    chk("stream_order", out_msg, exp);
                end
            end
            if (squash) sb.delete();
            else if (in_val && in_rdy) sb.push_back(in_msg);
        end
    end

    initial begin
        rst = 1'b0; in_val = 1'b0; out_rdy = 1'b0; squash = 1'b0; in_msg = '0;
        z_rst = 1'b0; z_in_val = 1'b0; z_out_rdy = 1'b0; z_squash = 1'b0; z_in_msg = '0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 4; i++) begin
            in_val  = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            squash  = 1'($urandom_range(0, 1));
            in_msg  = $urandom;
            step();
            chk("rst_out_val", out_val, 0);
            chk("rst_count", count, 0);
            chk("rst_out_msg", out_msg, RST1);
            chk("rst_in_rdy", in_rdy, 0);
        end
        chk("rst0_out_msg", z_out_msg, RST0);

        // Release reset between edges
        in_val = 1'b0; out_rdy = 1'b0; squash = 1'b0;
        rst = 1'b1; z_rst = 1'b1;
        #1;
        chk("release_in_rdy", in_rdy, 1);
        chk("release_count", count, 0);
        chk("release_out_val", out_val, 0);

        // Streaming with no backpressure
        out_rdy = 1'b1; in_val = 1'b1; in_msg = 32'h11;
        step();
        chk("stream_msg1", out_msg, 32'h11);
        chk("stream_cnt1", count, 1);
        in_msg = 32'h22;
        step();
        chk("stream_msg2", out_msg, 32'h22);
        chk("stream_cnt2", count, 1);
        in_msg = 32'h33;
        step();
        chk("stream_msg3", out_msg, 32'h33);
        chk("stream_cnt3", count, 1);
        in_val = 1'b0;
        step();
        chk("stream_drain", count, 0);

        // Backpressure fills the skid entry
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'hA0;
        step();
        in_msg = 32'hA1;
        step();
        in_msg = 32'hA2;
        chk("bp_count_full", count, 2);
        chk("bp_in_rdy", in_rdy, 0);
        chk("bp_head", out_msg, 32'hA0);
        step();
        chk("bp_hold_count", count, 2);
        chk("bp_hold_head", out_msg, 32'hA0);
        out_rdy = 1'b1;
        step();
        chk("bp_skid_to_head", out_msg, 32'hA1);
        chk("bp_count_one", count, 1);
        chk("bp_rdy_back", in_rdy, 1);
        step();
        chk("bp_last", out_msg, 32'hA2);
        chk("bp_last_cnt", count, 1);
        in_val = 1'b0;
        step();
        chk("bp_drained", count, 0);

        // Squash while FULL with a pending upstream message
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'hB0;
        step();
        in_msg = 32'hB1;
        step();
        chk("sq_full", count, 2);
        in_msg = 32'hFF; squash = 1'b1;
        #1;
        chk("sq_in_rdy", in_rdy, 0);
        step();
        squash = 1'b0; in_val = 1'b0; out_rdy = 1'b1;
        chk("sq_count", count, 0);
        chk("sq_out_val", out_val, 0);
        step();
        chk("sq_idle", out_val, 0);

        // Squash in the same cycle as a delivery
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'h55;
        step();
        in_val = 1'b0; out_rdy = 1'b1; squash = 1'b1;
        chk("sqf_head", out_msg, 32'h55);
        chk("sqf_val", out_val, 1);
        step();
        squash = 1'b0;
        chk("sqf_count", count, 0);
        chk("sqf_out_val", out_val, 0);

        // Asynchronous reset while FULL
        out_rdy = 1'b0; in_val = 1'b1; in_msg = 32'hC0;
        step();
        in_msg = 32'hC1;
        step();
        chk("ar_full", count, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_out_val", out_val, 0);
        chk("ar_count", count, 0);
        chk("ar_out_msg", out_msg, RST1);
        in_val = 1'b0; out_rdy = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("ar_after_val", out_val, 0);
        step();
        chk("ar_after_cnt", count, 0);
        chk("sb_empty", sb.size(), 0);

        // Single-entry mode: combinational ready
        z_in_val = 1'b1; z_in_msg = 8'h3C; z_out_rdy = 1'b0;
        #1;
        chk("ns_empty_rdy", z_in_rdy, 1);
        step();
        z_in_msg = 8'hA5;
        #1;
        chk("ns_one_rdy", z_in_rdy, 0);
        chk("ns_one_cnt", z_count, 1);
        chk("ns_one_msg", z_out_msg, 8'h3C);
        step();
        chk("ns_stall_cnt", z_count, 1);
        chk("ns_stall_msg", z_out_msg, 8'h3C);
        z_out_rdy = 1'b1; z_in_msg = 8'h7E;
        #1;
        chk("ns_comb_rdy", z_in_rdy, 1);
        step();
        chk("ns_new_msg", z_out_msg, 8'h7E);
        chk("ns_new_cnt", z_count, 1);
        chk("ns_new_val", z_out_val, 1);
        z_squash = 1'b1;
        #1;
        chk("ns_sq_rdy", z_in_rdy, 0);
        step();
        z_squash = 1'b0; z_in_val = 1'b0;
        chk("ns_sq_cnt", z_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
